// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, picks the next PC (pending branch, live
// branch, or sequential), drives the instruction SRAM and buffers one word for ID.
module fetch_stage #(
  parameter logic [31:0] RESET_PC    = 32'hBFC0_0000,
  parameter int          StallBus    = 6,
  parameter int          BR_WD       = 33,
  parameter int          IF_TO_ID_WD = 33
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic [StallBus-1:0]    stall_i,
  input  logic [BR_WD-1:0]       br_bus_i,
  input  logic [31:0]            inst_sram_rdata_i,
  output logic                   inst_sram_en_o,
  output logic [3:0]             inst_sram_wen_o,
  output logic [31:0]            inst_sram_addr_o,
  output logic [31:0]            inst_sram_wdata_o,
  output logic [IF_TO_ID_WD-1:0] if_to_id_bus_o,
  output logic [31:0]            inst_to_id_o
);

  localparam logic Stop = 1'b1;

  logic        pc_stall;
  logic        id_stall;
  logic        br_e;
  logic [31:0] br_addr;
  logic        unused_stall;

  logic [31:0] pc_q, pc_d;
  logic        ce_q, ce_d;
  logic        br_pending_q, br_pending_d;
  logic [31:0] br_target_q, br_target_d;
  logic        hold_valid_q, hold_valid_d;
  logic [31:0] hold_data_q, hold_data_d;
  logic [31:0] next_pc;

  assign pc_stall     = stall_i[0];
  assign id_stall     = stall_i[2];
  assign br_e         = br_bus_i[32];
  assign br_addr      = br_bus_i[31:0];
  assign unused_stall = ^{stall_i[StallBus-1:3], stall_i[1]};

  // A branch captured during a PC stall outranks one arriving on the release edge.
  always_comb begin
    if (br_pending_q)  next_pc = br_target_q;
    else if (br_e)     next_pc = br_addr;
    else               next_pc = pc_q + 32'd4;
  end

  always_comb begin
    pc_d         = pc_q;
    ce_d         = ce_q;
    br_pending_d = br_pending_q;
    br_target_d  = br_target_q;
    if (pc_stall != Stop) begin
      pc_d         = next_pc;
      ce_d         = 1'b1;
      br_pending_d = 1'b0;
    end else if (br_e) begin
      br_pending_d = 1'b1;
      br_target_d  = br_addr;
    end
  end

  // The buffer grabs the word ID was looking at on the first stalled edge only.
  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    if (id_stall == Stop) begin
      if (!hold_valid_q) begin
        hold_valid_d = 1'b1;
        hold_data_d  = inst_sram_rdata_i;
      end
    end else begin
      hold_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pc_q         <= RESET_PC - 32'd4;
      ce_q         <= 1'b0;
      br_pending_q <= 1'b0;
      br_target_q  <= 32'd0;
      hold_valid_q <= 1'b0;
      hold_data_q  <= 32'd0;
    end else begin
      pc_q         <= pc_d;
      ce_q         <= ce_d;
      br_pending_q <= br_pending_d;
      br_target_q  <= br_target_d;
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
    end
  end

  assign inst_sram_en_o    = ce_q;
  assign inst_sram_wen_o   = 4'b0000;
  assign inst_sram_addr_o  = pc_q;
  assign inst_sram_wdata_o = 32'd0;
  assign if_to_id_bus_o    = {ce_q, pc_q};
  assign inst_to_id_o      = hold_valid_q ? hold_data_q : inst_sram_rdata_i;

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch (IF) stage of the 5-stage MIPS pipeline. It sits directly upstream of ID and owns the PC register, next-PC selection, and the instruction-SRAM read port. It also holds a one-entry instruction buffer so that ID sees a stable instruction word across multi-cycle stalls. ID resolves branches and returns them on `br_bus`. IF presents `{ce, pc}` on `if_to_id_bus`, and ID registers that bus itself.

## Interface
- `RESET_PC`, 32'hBFC0_0000: address of the first fetched instruction.
- `clk` in 1: pipeline clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low (0 = reset); deassertion is synchronous to `clk` by the system.
- `stall` in `StallBus` (6): stall[0] holds PC; stall[2] indicates ID is held; other bits are ignored here.
- `br_bus` in `BR_WD` (33): {br_e, br_addr[31:0]} from ID, combinational, valid in the same cycle.
- `inst_sram_rdata` in 32: synchronous SRAM read data for the address presented in the previous cycle.
- `inst_sram_en` out 1: read enable.
- `inst_sram_wen` out 4: always 4'b0000.
- `inst_sram_addr` out 32: fetch address.
- `inst_sram_wdata` out 32: always 32'b0.
- `if_to_id_bus` out `IF_TO_ID_WD` (33): {ce, pc_reg}.
- `inst_to_id` out 32: instruction word ID must decode, replacing raw `inst_sram_rdata`.

## Operation
- State:
  - `pc_reg[31:0]`, reset `RESET_PC - 4`.
  - `ce`, reset 0.
  - `br_pending`, reset 0; `br_target[31:0]`, reset 0.
  - `hold_valid`, reset 0; `hold_data[31:0]`, reset 0.
- Next-PC priority: `br_pending` → `br_target`; else `br_e` → `br_addr`; else `pc_reg + 4`, with 32-bit wrap at 32'hFFFF_FFFC → 0.
- PC update, when `stall[0]` is NoStop: `pc_reg` ← next_pc, `ce` ← 1, `br_pending` ← 0.
- PC hold, when `stall[0]` is Stop:
  - `pc_reg` and `ce` hold.
  - If `br_e` = 1: `br_pending` ← 1 and `br_target` ← `br_addr`.
  - A later `br_e` in the same stall overwrites `br_target`: last one wins.
- Branch delay slot: when ID reports a branch, IF already holds the delay-slot PC. That slot is never squashed; only the following fetch is redirected.
- SRAM port: `inst_sram_en` = `ce`, `inst_sram_addr` = `pc_reg`, both combinational from state.
- Hold buffer, capture: on an edge where `stall[2]` = Stop and `hold_valid` = 0, `hold_data` ← `inst_sram_rdata` and `hold_valid` ← 1.
- Hold buffer, keep: while `stall[2]` stays Stop, `hold_valid` and `hold_data` hold.
- Hold buffer, release: on an edge where `stall[2]` = NoStop, `hold_valid` ← 0.
- `inst_to_id` = `hold_valid` ? `hold_data` : `inst_sram_rdata`.
- No misalignment check is done in this block. `br_addr[1:0]` ≠ 0 is passed through unchanged.

## Timing
- Reset (`rst` = 0, any time, asynchronous):
  - `ce` = 0, `pc_reg` = 32'hBFBF_FFFC, `if_to_id_bus` = {1'b0, 32'hBFBF_FFFC}.
  - `inst_sram_en` = 0, `inst_sram_addr` = 32'hBFBF_FFFC.
  - `hold_valid` = 0, `inst_to_id` = `inst_sram_rdata`.
  - `br_pending` is cleared.
- First edge after `rst` rises (stall[0] NoStop): `pc_reg` = `RESET_PC`, `ce` = 1.
- Fetch latency: address presented in cycle N → `inst_sram_rdata` valid in cycle N+1, which is when ID decodes it.
- Branch: `br_e` in cycle N with stall[0] NoStop → `pc_reg` = `br_addr` from cycle N+1.
- Branch under stall: redirect is taken on the first unstalled edge.
- `br_e` on the same edge that a pending branch is consumed: the pending target wins and the new `br_e` is dropped. ID never issues two branches back-to-back; the bench checks this as an assertion.
- Capture: `hold_data` is captured on the first stalled edge only. Its value is the word ID held in the cycle the stall was first asserted.
- Release: in the cycle `stall[2]` drops, `inst_to_id` still equals `hold_data`. Raw SRAM data resumes one cycle later.
- Reset asserted mid-stall or mid-pending: all state clears immediately and the pending branch is lost.

## Test plan
- Reset release: `rst` low 3 cycles, then high with no stalls → `inst_sram_addr` sequence BFBFFFFC (en=0), BFC00000, BFC00004, BFC00008; `ce` rises on the first edge.
- Taken branch: `br_bus` = {1, 32'hBFC0_0100} for one cycle while `pc_reg` = BFC00008 → next addresses BFC00100, BFC00104.
- Branch during PC stall: stall[0] = Stop for 3 cycles, `br_e` pulsed in the 2nd with target BFC00200 → `pc_reg` holds; on release `pc_reg` = BFC00200 and `br_pending` = 0.
- Load-use stall:
  - Stimulus: SRAM returns 0x8C010000 in cycle N, then 0x00221821; stall[0..2] = Stop in cycles N and N+1.
  - Required response: `inst_to_id` = 0x8C010000 in cycles N, N+1 and N+2, then 0x00221821.
- Async reset mid-operation: assert `rst` = 0 between clock edges during a pending branch and an active hold → outputs reach reset values before the next edge, with `hold_valid` = 0 and `ce` = 0.
- PC wrap: force `pc_reg` = 32'hFFFF_FFFC with no branch → next `pc_reg` = 32'h0000_0000.
